// File: rtl/rf_mp.sv
// Multi-port register file with optional write-to-read bypass and a per-register
// busy scoreboard (decode reserves a destination, writeback clears it).
module rf_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      wen,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [NREG-1:0]     busy_vec
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Next state: writes in port order so the higher port wins; reserve applied last
  // so a new producer overrides a same-cycle writeback clear.
  always_comb begin : next_state
    logic [AW-1:0] wa;
    wa     = '0;
    regs_d = regs_q;
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      wa = waddr[j*AW +: AW];
      if (wen[j] && !(ZR && (wa == '0))) begin
        regs_d[wa] = wdata[j*XLEN +: XLEN];
        busy_d[wa] = 1'b0;
      end else begin
        regs_d[wa] = regs_d[wa];
      end
    end
    if (rsv_en && !(ZR && (rsv_addr == '0))) begin
      busy_d[rsv_addr] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read ports; the bypass is suppressed while reset is asserted so reads show
  // stored contents, and register 0 overrides everything when hardwired.
  always_comb begin : read_ports
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            rb;
    ra    = '0;
    rd    = '0;
    rb    = 1'b0;
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = raddr[i*AW +: AW];
      rd = regs_q[ra];
      rb = busy_q[ra];
      if (BP && !rst) begin
        for (int j = 0; j < NWR; j++) begin
          if (wen[j] && (waddr[j*AW +: AW] == ra)) begin
            rd = wdata[j*XLEN +: XLEN];
            if (!(rsv_en && (rsv_addr == ra))) begin
              rb = 1'b0;
            end else begin
              rb = rb;
            end
          end else begin
            rd = rd;
          end
        end
      end else begin
        rd = rd;
      end
      if (ZR && (ra == '0)) begin
        rd = '0;
        rb = 1'b0;
      end else begin
        rb = rb;
      end
      rdata[i*XLEN +: XLEN] = rd;
      rbusy[i]              = rb;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_rf_mp.sv
// Self-checking bench for rf_mp: two instances (zero-reg + bypass, and plain
// register 0 without bypass) share one stimulus and are compared to a reference model.
module tb_rf_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NRD*AW-1:0]   raddr;
  logic [NWR-1:0]      wen;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic [NRD*XLEN-1:0] rdata_a, rdata_b;
  logic [NRD-1:0]      rbusy_a, rbusy_b;
  logic [NREG-1:0]     bv_a, bv_b;

  rf_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a), .wen(wen),
    .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(bv_a));

  rf_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b), .wen(wen),
    .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(bv_b));

  // Reference state: index 0 models dut_a, index 1 models dut_b.
  logic [XLEN-1:0] mreg  [2][NREG];
  logic            mbusy [2][NREG];
  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        rst;
    logic [1:0]  wen;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        rsv;
    logic [4:0]  rsv_a;
    logic [4:0]  ra0;
    logic [31:0] exp_a;
    logic        exp_rb_a;
    logic [31:0] exp_b;
    logic [31:0] exp_bv_a, exp_bv_b;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic r, input logic [1:0] we, input logic [4:0] a0,
                              input logic [4:0] a1, input logic [31:0] d0, input logic [31:0] d1,
                              input logic rv, input logic [4:0] rva, input logic [4:0] ra,
                              input logic [31:0] ea, input logic erb, input logic [31:0] eb,
                              input logic [31:0] bva, input logic [31:0] bvb);
    vec_t v;
    v.rst = r; v.wen = we; v.wa0 = a0; v.wa1 = a1; v.wd0 = d0; v.wd1 = d1;
    v.rsv = rv; v.rsv_a = rva; v.ra0 = ra; v.exp_a = ea; v.exp_rb_a = erb; v.exp_b = eb;
    v.exp_bv_a = bva; v.exp_bv_b = bvb;
    return v;
  endfunction

  task automatic drive(input logic r, input logic [1:0] we, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1, input logic rv,
                       input logic [4:0] rva, input logic [4:0] ra0, input logic [4:0] ra1);
    rst = r; wen = we; waddr = {a1, a0}; wdata = {d1, d0};
    rsv_en = rv; rsv_addr = rva; raddr = {ra1, ra0};
  endtask

  function automatic logic write_hits(input logic [4:0] ra);
    for (int j = 0; j < NWR; j++)
      if (wen[j] && waddr[j*AW +: AW] == ra) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_rdata(input int c, input logic [4:0] ra);
    logic [31:0] v;
    if (c == 0 && ra == 5'd0) return 32'd0;
    v = mreg[c][ra];
    if (c == 0 && !rst)
      for (int j = 0; j < NWR; j++)
        if (wen[j] && waddr[j*AW +: AW] == ra) v = wdata[j*XLEN +: XLEN];
    return v;
  endfunction

  function automatic logic m_rbusy(input int c, input logic [4:0] ra);
    if (c == 0 && ra == 5'd0) return 1'b0;
    if (c == 0 && !rst && write_hits(ra) && !(rsv_en && rsv_addr == ra)) return 1'b0;
    return mbusy[c][ra];
  endfunction

  task automatic m_update();
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        for (int r = 0; r < NREG; r++) begin mreg[c][r] = 32'd0; mbusy[c][r] = 1'b0; end
      end else begin
        for (int j = 0; j < NWR; j++) begin
          if (wen[j] && !(c == 0 && waddr[j*AW +: AW] == 5'd0)) begin
            mreg[c][waddr[j*AW +: AW]]  = wdata[j*XLEN +: XLEN];
            mbusy[c][waddr[j*AW +: AW]] = 1'b0;
          end
        end
        if (rsv_en && !(c == 0 && rsv_addr == 5'd0)) mbusy[c][rsv_addr] = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    logic [31:0] ebv;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < NRD; i++) begin
        chk($sformatf("cfg%0d rdata%0d", c, i),
            (c == 0) ? rdata_a[i*XLEN +: XLEN] : rdata_b[i*XLEN +: XLEN],
            m_rdata(c, raddr[i*AW +: AW]));
        chk($sformatf("cfg%0d rbusy%0d", c, i),
            {31'd0, (c == 0) ? rbusy_a[i] : rbusy_b[i]}, {31'd0, m_rbusy(c, raddr[i*AW +: AW])});
      end
      for (int r = 0; r < NREG; r++) ebv[r] = mbusy[c][r];
      chk($sformatf("cfg%0d busy_vec", c), (c == 0) ? bv_a : bv_b, ebv);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    m_update();
    #1;
  endtask

  initial begin
    tbl[0]  = mk(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd5, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    tbl[1]  = mk(1'b1, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0, 5'd5, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    tbl[2]  = mk(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd5, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    tbl[3]  = mk(1'b0, 2'b11, 5'd7, 5'd7, 32'h11111111, 32'h22222222, 1'b0, 5'd0, 5'd7, 32'h22222222, 1'b0, 32'h0, 32'h0, 32'h0);
    tbl[4]  = mk(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 32'h22222222, 1'b0, 32'h22222222, 32'h0, 32'h0);
    tbl[5]  = mk(1'b0, 2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 1'b1, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    tbl[6]  = mk(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h1);
    tbl[7]  = mk(1'b0, 2'b01, 5'd3, 5'd0, 32'h12345678, 32'h0, 1'b0, 5'd0, 5'd3, 32'h12345678, 1'b0, 32'h0, 32'h0, 32'h1);
    tbl[8]  = mk(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 32'h12345678, 1'b0, 32'h12345678, 32'h0, 32'h1);
    tbl[9]  = mk(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9, 5'd9, 32'h0, 1'b0, 32'h0, 32'h0, 32'h1);
    tbl[10] = mk(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 32'h0, 1'b1, 32'h0, 32'h200, 32'h201);
    tbl[11] = mk(1'b0, 2'b01, 5'd9, 5'd0, 32'hA5A5A5A5, 32'h0, 1'b0, 5'd0, 5'd9, 32'hA5A5A5A5, 1'b0, 32'h0, 32'h200, 32'h201);
    tbl[12] = mk(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 32'h0, 32'h1);
    tbl[13] = mk(1'b0, 2'b01, 5'd4, 5'd0, 32'hCAFEF00D, 32'h0, 1'b1, 5'd4, 5'd4, 32'hCAFEF00D, 1'b0, 32'h0, 32'h0, 32'h1);
    tbl[14] = mk(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd4, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 32'h10, 32'h11);
    tbl[15] = mk(1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd4, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 32'h10, 32'h11);
    tbl[16] = mk(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd4, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);

    drive(1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    m_update();
    #1;

    // Sweep every address right after reset on both ports.
    for (int a = 0; a < NREG; a += 2) begin
      drive(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'(a), 5'(a + 1));
      @(negedge clk);
      chk("post-reset rdata_a", rdata_a[31:0] | rdata_a[63:32], 32'h0);
      chk("post-reset rdata_b", rdata_b[31:0] | rdata_b[63:32], 32'h0);
      check_model();
      advance();
    end

    for (int k = 0; k < 17; k++) begin
      drive(tbl[k].rst, tbl[k].wen, tbl[k].wa0, tbl[k].wa1, tbl[k].wd0, tbl[k].wd1,
            tbl[k].rsv, tbl[k].rsv_a, tbl[k].ra0, 5'd0);
      @(negedge clk);
      chk($sformatf("vec%0d rdata_a", k), rdata_a[31:0], tbl[k].exp_a);
      chk($sformatf("vec%0d rbusy_a", k), {31'd0, rbusy_a[0]}, {31'd0, tbl[k].exp_rb_a});
      chk($sformatf("vec%0d rdata_b", k), rdata_b[31:0], tbl[k].exp_b);
      chk($sformatf("vec%0d busy_vec_a", k), bv_a, tbl[k].exp_bv_a);
      chk($sformatf("vec%0d busy_vec_b", k), bv_b, tbl[k].exp_bv_b);
      check_model();
      advance();
    end

    // Randomised traffic on a small address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      drive(1'b0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      @(negedge clk);
      check_model();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
